// File: rtl/mac_accumulator_pkg.sv
// Shared widths and state encodings for the MAC accumulate stage.
package mac_accumulator_pkg;

  localparam int unsigned PROD_W_DEF  = 4;
  localparam int unsigned ACC_W_DEF   = 8;
  localparam int unsigned COUNT_W_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/mac_acc_adder.sv
// Unsigned accumulator adder: ACC_W-bit running sum plus a zero-extended product, with carry-out.
module mac_acc_adder #(
  parameter int unsigned PROD_W = 4,
  parameter int unsigned ACC_W  = 8
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_acc} + (ACC_W + 1)'(i_prod);
  assign o_sum   = w_full[ACC_W-1:0];
  assign o_carry = w_full[ACC_W];

endmodule

// File: rtl/mac_accumulator.sv
// Frame accumulator: sums products until in_last, then holds sum/count/overflow until taken.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int unsigned PROD_W  = PROD_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PROD_W-1:0]  in_product,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               overflow
);

  if (ACC_W < PROD_W) begin : g_bad_width
    $error("mac_accumulator: ACC_W must be at least PROD_W");
  end

  logic [1:0]         r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [COUNT_W-1:0] r_count;
  logic               r_ovf;

  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic               w_accept;

  mac_acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .i_acc   (r_acc),
    .i_prod  (in_product),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // rst gates in_ready combinationally so upstream sees no ready during reset.
  assign in_ready  = !rst && (r_state != ST_HOLD);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_HOLD);
  assign out_sum   = r_acc;
  assign out_count = r_count;
  assign overflow  = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc   <= ACC_W'(in_product);
            r_count <= COUNT_W'(1);
            r_ovf   <= 1'b0;
            r_state <= in_last ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum;
            r_ovf   <= r_ovf | w_carry;
            if (r_count != '1) r_count <= r_count + COUNT_W'(1);
            r_state <= in_last ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_acc   <= '0;
          r_count <= '0;
          r_ovf   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and randomised self-checking bench for mac_accumulator.
module tb_mac_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_product;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [3:0] out_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  mac_accumulator #(
    .PROD_W  (4),
    .ACC_W   (8),
    .COUNT_W (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [3:0] p, input logic last);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    tick();
  endtask

  task automatic no_beat();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_product = 4'd0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] s,
                         input logic [3:0] c, input logic o);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sum"},   32'(out_sum),   32'(s));
    chk({tag, ".count"}, 32'(out_count), 32'(c));
    chk({tag, ".ovf"},   32'(overflow),  32'(o));
  endtask

  // Reference model state for the random phase
  int m_state;  // 0 idle, 1 accum, 2 hold
  int m_acc;
  int m_cnt;
  int m_ovf;
  int frames;
  int cycles;
  logic       r_v;
  logic [3:0] r_p;
  logic       r_l;
  logic       r_or;

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    out_ready  = 1'b1;
    no_beat();
    #2;
    chk_out("reset", 1'b0, 8'd0, 4'd0, 1'b0);
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_reset.in_ready", 32'(in_ready), 32'd1);

    // Frame 9,6,4,2 with consumer always ready
    beat(4'd9, 1'b0);
    chk_out("f1.mid", 1'b0, 8'd9, 4'd1, 1'b0);
    beat(4'd6, 1'b0);
    beat(4'd4, 1'b0);
    beat(4'd2, 1'b1);
    no_beat();
    chk_out("f1.hold", 1'b1, 8'd21, 4'd4, 1'b0);
    chk("f1.hold.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk_out("f1.idle", 1'b0, 8'd0, 4'd0, 1'b0);
    chk("f1.idle.in_ready", 32'(in_ready), 32'd1);

    // Single beat, consumer stalls; an offered beat must not be consumed
    out_ready = 1'b0;
    beat(4'd4, 1'b1);
    in_valid   = 1'b1;
    in_product = 4'd7;
    in_last    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("f2.stall", 1'b1, 8'd4, 4'd1, 1'b0);
      chk("f2.stall.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    no_beat();
    out_ready = 1'b1;
    tick();
    chk_out("f2.idle", 1'b0, 8'd0, 4'd0, 1'b0);
    beat(4'd1, 1'b0);
    beat(4'd1, 1'b1);
    no_beat();
    chk_out("f3.hold", 1'b1, 8'd2, 4'd2, 1'b0);
    tick();

    // 29 beats of 9: 261 wraps to 5, overflow set, count saturates
    for (int i = 0; i < 28; i++) beat(4'd9, 1'b0);
    beat(4'd9, 1'b1);
    no_beat();
    chk_out("f4.hold", 1'b1, 8'd5, 4'd15, 1'b1);
    tick();
    beat(4'd3, 1'b1);
    no_beat();
    chk_out("f5.hold", 1'b1, 8'd3, 4'd1, 1'b0);
    tick();

    // clear aborts the frame and drops the concurrent beat
    beat(4'd9, 1'b0);
    beat(4'd9, 1'b0);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_product = 4'd6;
    in_last    = 1'b0;
    #1;
    chk("clear.in_ready", 32'(in_ready), 32'd1);
    tick();
    clear = 1'b0;
    no_beat();
    chk_out("clear.idle", 1'b0, 8'd0, 4'd0, 1'b0);
    beat(4'd1, 1'b0);
    beat(4'd2, 1'b1);
    no_beat();
    chk_out("f6.hold", 1'b1, 8'd3, 4'd2, 1'b0);
    tick();

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    beat(4'd9, 1'b0);
    beat(4'd6, 1'b0);
    beat(4'd4, 1'b0);
    beat(4'd2, 1'b1);
    no_beat();
    chk_out("f7.hold", 1'b1, 8'd21, 4'd4, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 8'd0, 4'd0, 1'b0);
    chk("async_rst.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_rel.in_ready", 32'(in_ready), 32'd1);

    // Random traffic against a reference model
    m_state = 0;
    m_acc   = 0;
    m_cnt   = 0;
    m_ovf   = 0;
    frames  = 0;
    cycles  = 0;
    while (frames < 1000 && cycles < 60000) begin
      chk("rnd.out_valid", 32'(out_valid), 32'(m_state == 2));
      chk("rnd.in_ready",  32'(in_ready),  32'(m_state != 2));
      if (m_state == 2) begin
        chk("rnd.sum",   32'(out_sum),   32'(m_acc));
        chk("rnd.count", 32'(out_count), 32'(m_cnt));
        chk("rnd.ovf",   32'(overflow),  32'(m_ovf));
      end
      r_v  = 1'($urandom_range(0, 1));
      r_p  = 4'($urandom_range(0, 15));
      r_l  = ($urandom_range(0, 7) == 0);
      r_or = 1'($urandom_range(0, 1));
      in_valid   = r_v;
      in_product = r_p;
      in_last    = r_l;
      out_ready  = r_or;
      if (m_state != 2 && r_v) begin
        if (m_state == 0) begin
          m_acc = int'(r_p);
          m_cnt = 1;
          m_ovf = 0;
        end else begin
          m_acc = m_acc + int'(r_p);
          if (m_acc > 255) begin
            m_ovf = 1;
            m_acc = m_acc - 256;
          end
          if (m_cnt < 15) m_cnt = m_cnt + 1;
        end
        m_state = r_l ? 2 : 1;
      end else if (m_state == 2 && r_or) begin
        m_state = 0;
        m_acc   = 0;
        m_cnt   = 0;
        m_ovf   = 0;
        frames++;
      end
      tick();
      cycles++;
    end
    chk("rnd.frames_done", 32'(frames), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
